// File: rtl/cpu_pkg.sv
// Shared definitions for the operand-fetch stage of the 8-bit ALU datapath:
// opcodes, ALU operation encodings, FSM states and the instruction decoder.
package cpu_pkg;

   localparam int DATA_W = 8;
   localparam int REG_AW = 3;

   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;

   localparam logic [2:0] ALU_FWD = 3'b000;
   localparam logic [2:0] ALU_ADD = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

   typedef struct packed {
      logic              legal;
      logic              arith;
      logic [2:0]        op;
      logic [DATA_W-1:0] d1;
      logic [DATA_W-1:0] d2;
   } decode_t;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      return ~v + 8'd1;
   endfunction

   // Maps an opcode plus the already-read source values onto ALU operands.
   function automatic decode_t decode(input logic [7:0]        opcode,
                                      input logic [DATA_W-1:0] rs1,
                                      input logic [DATA_W-1:0] rs2,
                                      input logic [DATA_W-1:0] imm);
      decode_t r;
      r       = '0;
      r.legal = 1'b1;
      case (opcode)
         OP_LOADI: begin r.op = ALU_FWD; r.d2 = imm;                         end
         OP_MOV:   begin r.op = ALU_FWD; r.d2 = rs2;                         end
         OP_ADD:   begin r.op = ALU_ADD; r.d1 = rs1; r.d2 = rs2; r.arith = 1'b1; end
         OP_SUB:   begin r.op = ALU_ADD; r.d1 = rs1; r.d2 = negate(rs2); r.arith = 1'b1; end
         OP_AND:   begin r.op = ALU_AND; r.d1 = rs1; r.d2 = rs2;             end
         OP_OR:    begin r.op = ALU_OR;  r.d1 = rs1; r.d2 = rs2;             end
         default:  r.legal = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Instruction handshake plus the operand/result bus towards the combinational ALU.
interface operand_fetch_if;
   import cpu_pkg::*;

   logic              instr_valid;
   logic              instr_ready;
   logic [31:0]       instr;
   logic [DATA_W-1:0] data1;
   logic [DATA_W-1:0] data2;
   logic [2:0]        operation;
   logic [DATA_W-1:0] alu_result;
   logic              alu_co;

   modport master (
      output instr_valid, instr, alu_result, alu_co,
      input  instr_ready, data1, data2, operation
   );

   modport slave (
      input  instr_valid, instr, alu_result, alu_co,
      output instr_ready, data1, data2, operation
   );

endinterface

// File: rtl/operand_fetch_reg_file.sv
// 8x8 register file: two combinational read ports, a debug read port and one
// synchronous write port; contents clear asynchronously on reset.
module reg_file
   import cpu_pkg::*;
#(
   parameter int NREGS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata1   = mem_q[raddr1];
   assign rdata2   = mem_q[raddr2];
   assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: accepts an instruction, drives registered operands into
// the ALU, waits ALU_WAIT cycles, then writes the result back to the register file.
module operand_fetch
   import cpu_pkg::*;
#(
   parameter int ALU_WAIT = 2,
   parameter int NREGS    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   operand_fetch_if.slave    bus,
   output logic              done,
   output logic              illegal,
   output logic              carry_flag,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] data1_q, data1_d;
   logic [DATA_W-1:0] data2_q, data2_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic              arith_q, arith_d;
   logic              done_q, done_d;
   logic              illegal_q, illegal_d;
   logic              carry_q, carry_d;

   logic              we;
   logic [DATA_W-1:0] rd1, rd2;
   decode_t           dec;

   reg_file #(.NREGS(NREGS)) u_regs (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we),
      .waddr    (dest_q),
      .wdata    (bus.alu_result),
      .raddr1   (bus.instr[10:8]),
      .rdata1   (rd1),
      .raddr2   (bus.instr[2:0]),
      .rdata2   (rd2),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   assign dec = decode(bus.instr[31:24], rd1, rd2, bus.instr[7:0]);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data1_d   = data1_q;
      data2_d   = data2_q;
      op_d      = op_q;
      dest_d    = dest_q;
      arith_d   = arith_q;
      carry_d   = carry_q;
      done_d    = 1'b0;
      illegal_d = 1'b0;
      we        = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.instr_valid) begin
               if (dec.legal) begin
                  data1_d = dec.d1;
                  data2_d = dec.d2;
                  op_d    = dec.op;
                  arith_d = dec.arith;
                  dest_d  = bus.instr[18:16];
                  cnt_d   = 4'(ALU_WAIT - 1);
                  state_d = EXEC;
               end else begin
                  illegal_d = 1'b1;
               end
            end
         end
         EXEC: begin
            // Operands stay frozen here so the ALU output can settle.
            if (cnt_q == 4'd0) state_d = WB;
            else               cnt_d   = cnt_q - 4'd1;
         end
         WB: begin
            we      = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
            if (arith_q) carry_d = bus.alu_co;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         data1_q   <= '0;
         data2_q   <= '0;
         op_q      <= '0;
         dest_q    <= '0;
         arith_q   <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         carry_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data1_q   <= data1_d;
         data2_q   <= data2_d;
         op_q      <= op_d;
         dest_q    <= dest_d;
         arith_q   <= arith_d;
         done_q    <= done_d;
         illegal_q <= illegal_d;
         carry_q   <= carry_d;
      end
   end

   assign bus.instr_ready = (state_q == IDLE);
   assign bus.data1       = data1_q;
   assign bus.data2       = data2_q;
   assign bus.operation   = op_q;
   assign done            = done_q;
   assign illegal         = illegal_q;
   assign carry_flag      = carry_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural combinational ALU.
module tb_operand_fetch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       done, illegal, carry_flag;
   logic [2:0] dbg_addr;
   logic [7:0] dbg_data;

   int n_checks = 0;
   int n_errors = 0;
   int done_cnt = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   operand_fetch_if ifc();

   operand_fetch #(.ALU_WAIT(2), .NREGS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (ifc.slave),
      .done       (done),
      .illegal    (illegal),
      .carry_flag (carry_flag),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   // Reference ALU: fwd / add / and / or.
   always_comb begin
      logic [8:0] sum;
      sum            = {1'b0, ifc.data1} + {1'b0, ifc.data2};
      ifc.alu_result = 8'h00;
      ifc.alu_co     = 1'b0;
      case (ifc.operation)
         3'b000: ifc.alu_result = ifc.data2;
         3'b001: {ifc.alu_co, ifc.alu_result} = sum;
         3'b010: ifc.alu_result = ifc.data1 & ifc.data2;
         3'b011: ifc.alu_result = ifc.data1 | ifc.data2;
         default: ifc.alu_result = 8'h00;
      endcase
   end

   always @(negedge clk) if (done) done_cnt++;
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] opc, input logic [2:0] dst,
                                      input logic [2:0] s1, input logic [7:0] s2);
      return {opc, 5'b0, dst, 5'b0, s1, s2};
   endfunction

   task automatic reg_is(input int idx, input logic [7:0] exp);
      @(negedge clk);
      dbg_addr = 3'(idx);
      #1;
      check($sformatf("r%0d", idx), {24'h0, dbg_data}, {24'h0, exp});
   endtask

   task automatic run(input logic [31:0] ins, output logic [7:0] d1, output logic [7:0] d2,
                      output logic [2:0] op, output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!ifc.instr_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      ifc.instr       = ins;
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      d1  = ifc.data1;
      d2  = ifc.data2;
      op  = ifc.operation;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done && lat < 20);
   endtask

   initial begin
      logic [7:0]  d1, d2;
      logic [2:0]  op;
      int          lat, c0, idx, guard;
      int          acc[4];
      logic [31:0] q[4];

      ifc.instr_valid = 1'b0;
      ifc.instr       = '0;
      dbg_addr        = '0;

      repeat (2) @(negedge clk);
      check("rst_ready", {31'h0, ifc.instr_ready}, 1);
      check("rst_data1", {24'h0, ifc.data1}, 0);
      check("rst_data2", {24'h0, ifc.data2}, 0);
      check("rst_op", {29'h0, ifc.operation}, 0);
      check("rst_done", {31'h0, done}, 0);
      check("rst_illegal", {31'h0, illegal}, 0);
      check("rst_carry", {31'h0, carry_flag}, 0);
      rst_n = 1'b1;

      run(mk(8'h00, 3'd1, 3'd0, 8'h05), d1, d2, op, lat);
      check("loadi_lat", lat, 4);
      check("loadi_d2", {24'h0, d2}, 8'h05);
      run(mk(8'h00, 3'd2, 3'd0, 8'h03), d1, d2, op, lat);
      run(mk(8'h02, 3'd3, 3'd1, 8'h02), d1, d2, op, lat);
      check("add_d1", {24'h0, d1}, 8'h05);
      check("add_d2", {24'h0, d2}, 8'h03);
      check("add_op", {29'h0, op}, 1);
      check("add_lat", lat, 4);
      reg_is(3, 8'h08);
      check("add_carry", {31'h0, carry_flag}, 0);
      check("done_cnt3", done_cnt, 3);

      run(mk(8'h03, 3'd4, 3'd1, 8'h02), d1, d2, op, lat);
      check("sub_d2", {24'h0, d2}, 8'hFD);
      check("sub_op", {29'h0, op}, 1);
      reg_is(4, 8'h02);
      check("sub_carry", {31'h0, carry_flag}, 1);

      run(mk(8'h00, 3'd5, 3'd0, 8'hFF), d1, d2, op, lat);
      run(mk(8'h00, 3'd6, 3'd0, 8'h01), d1, d2, op, lat);
      run(mk(8'h02, 3'd7, 3'd5, 8'h06), d1, d2, op, lat);
      reg_is(7, 8'h00);
      check("add_ovf_carry", {31'h0, carry_flag}, 1);
      run(mk(8'h04, 3'd0, 3'd5, 8'h01), d1, d2, op, lat);
      check("and_op", {29'h0, op}, 2);
      reg_is(0, 8'h05);
      check("and_carry_kept", {31'h0, carry_flag}, 1);

      // Illegal opcode
      c0 = done_cnt;
      @(negedge clk);
      ifc.instr       = mk(8'h07, 3'd3, 3'd1, 8'h02);
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      check("ill_pulse", {31'h0, illegal}, 1);
      check("ill_ready", {31'h0, ifc.instr_ready}, 1);
      check("ill_data1_held", {24'h0, ifc.data1}, 8'hFF);
      check("ill_op_held", {29'h0, ifc.operation}, 2);
      @(posedge clk);
      #1;
      check("ill_one_cycle", {31'h0, illegal}, 0);
      repeat (4) @(negedge clk);
      check("ill_no_done", done_cnt, c0);
      reg_is(3, 8'h08);
      reg_is(0, 8'h05);

      // Reset while in EXEC
      @(negedge clk);
      ifc.instr       = mk(8'h02, 3'd3, 3'd1, 8'h02);
      ifc.instr_valid = 1'b1;
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      @(posedge clk);
      #1;
      check("exec_busy", {31'h0, ifc.instr_ready}, 0);
      c0    = done_cnt;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", {31'h0, ifc.instr_ready}, 1);
      check("mid_rst_data1", {24'h0, ifc.data1}, 0);
      check("mid_rst_op", {29'h0, ifc.operation}, 0);
      check("mid_rst_carry", {31'h0, carry_flag}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("mid_rst_no_done", done_cnt, c0);
      reg_is(1, 8'h00);
      reg_is(3, 8'h00);
      reg_is(5, 8'h00);
      run(mk(8'h00, 3'd2, 3'd0, 8'h44), d1, d2, op, lat);
      check("post_rst_lat", lat, 4);
      reg_is(2, 8'h44);

      // Back-to-back with instr_valid held high
      q[0] = mk(8'h00, 3'd1, 3'd0, 8'h0F);
      q[1] = mk(8'h05, 3'd3, 3'd1, 8'h02);
      q[2] = mk(8'h01, 3'd4, 3'd0, 8'hFA) | 32'h00F8_F800;
      q[3] = mk(8'h04, 3'd5, 3'd3, 8'h02);
      idx   = 0;
      guard = 0;
      @(negedge clk);
      ifc.instr       = q[0];
      ifc.instr_valid = 1'b1;
      while (idx < 4 && guard < 100) begin
         if (ifc.instr_ready) begin
            acc[idx] = cyc;
            if (idx > 0) check("b2b_done_with_ready", {31'h0, done}, 1);
            @(posedge clk);
            #1;
            idx++;
            if (idx < 4) ifc.instr = q[idx];
            else         ifc.instr_valid = 1'b0;
         end
         @(negedge clk);
         guard++;
      end
      check("b2b_all_accepted", idx, 4);
      for (int i = 1; i < 4; i++) check($sformatf("b2b_gap%0d", i), acc[i] - acc[i-1], 4);
      guard = 0;
      while (!done && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("b2b_last_done", {31'h0, done}, 1);
      reg_is(1, 8'h0F);
      reg_is(3, 8'h4F);
      reg_is(4, 8'h44);
      reg_is(5, 8'h44);

      run(mk(8'h00, 3'd7, 3'd0, 8'hFF), d1, d2, op, lat);
      run(mk(8'h02, 3'd6, 3'd7, 8'h03), d1, d2, op, lat);
      reg_is(6, 8'h4E);
      check("add2_carry", {31'h0, carry_flag}, 1);
      run(mk(8'h03, 3'd6, 3'd1, 8'h00), d1, d2, op, lat);
      check("sub0_d2", {24'h0, d2}, 8'h00);
      reg_is(6, 8'h0F);
      check("sub0_carry", {31'h0, carry_flag}, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
